// File: rtl/ecg_sched_pkg.sv
// Shared types and constants for the ECG sample scheduler.
// Holds the scheduler FSM encoding, default parameter values and the source timeout limit.
package ecg_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_CTR_WIDTH  = 24;
  localparam int DEF_DIV_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // cycles allowed between src_req and src_valid before the request is abandoned
  localparam int TIMEOUT_LIMIT  = 16;
  localparam int TO_CNT_WIDTH   = 5;

endpackage

// File: rtl/ecg_sync_fifo.sv
// Single-clock FIFO buffering fetched samples ahead of the algorithm core.
// Registered head read: a push into an empty FIFO becomes visible the next cycle.
module ecg_sync_fifo
  import ecg_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == CW'(FIFO_DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/ecg_sample_sched.sv
// Paces sample fetches from an ECG source at a programmable rate and streams them out.
// Define ECG_SAMPLE_SCHED_TIMEOUT_EN to abandon source requests unanswered for 16 cycles.
module ecg_sample_sched
  import ecg_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CTR_WIDTH  = DEF_CTR_WIDTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic [CTR_WIDTH-1:0]  num_samples,
  output logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTR_WIDTH-1:0]  out_index,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  src_timeout
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e          state_r, state_s;
  logic [DIV_WIDTH-1:0]  div_r, cnt_r, eff_div_s;
  logic [CTR_WIDTH-1:0]  num_r, issued_r, out_index_r;
  logic                  outstanding_r, overrun_r, src_req_r;
  logic                  tick_s, issue_s, block_s, start_acc_s, timeout_s;
  logic                  push_s, pop_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [FCW-1:0]        fifo_count_s;

  assign eff_div_s = (rate_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : rate_div;
  assign tick_s    = (state_r == ST_RUN) && (cnt_r == DIV_WIDTH'(0));
  assign push_s    = src_valid && outstanding_r && !fifo_full_s;
  assign pop_s     = !fifo_empty_s && out_ready;

  assign src_req   = src_req_r;
  assign out_valid = !fifo_empty_s;
  assign out_index = out_index_r;
  assign busy      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign done      = (state_r == ST_DONE);
  assign overrun   = overrun_r;

  // Next-state and tick arbitration; stop takes priority over a same-cycle tick.
  always_comb begin
    state_s     = state_r;
    issue_s     = 1'b0;
    block_s     = 1'b0;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          state_s     = (num_samples == CTR_WIDTH'(0)) ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop || (issued_r == num_r)) begin
          state_s = ST_DRAIN;
        end else if (tick_s) begin
          if (!outstanding_r && ((fifo_count_s + FCW'(outstanding_r)) < FCW'(FIFO_DEPTH))) begin
            issue_s = 1'b1;
          end else begin
            block_s = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!outstanding_r && fifo_empty_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Scheduler state, rate counter, run bookkeeping and request strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= ST_IDLE;
      div_r         <= DIV_WIDTH'(0);
      cnt_r         <= DIV_WIDTH'(0);
      num_r         <= CTR_WIDTH'(0);
      issued_r      <= CTR_WIDTH'(0);
      out_index_r   <= CTR_WIDTH'(0);
      outstanding_r <= 1'b0;
      overrun_r     <= 1'b0;
      src_req_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      src_req_r <= issue_s;
      if (start_acc_s) begin
        div_r       <= eff_div_s;
        cnt_r       <= eff_div_s - DIV_WIDTH'(1);
        num_r       <= num_samples;
        issued_r    <= CTR_WIDTH'(0);
        out_index_r <= CTR_WIDTH'(0);
        overrun_r   <= 1'b0;
      end else begin
        if (state_r == ST_RUN) cnt_r <= tick_s ? (div_r - DIV_WIDTH'(1)) : (cnt_r - DIV_WIDTH'(1));
        if (issue_s) issued_r <= issued_r + CTR_WIDTH'(1);
        if (block_s) overrun_r <= 1'b1;
        if (pop_s)   out_index_r <= out_index_r + CTR_WIDTH'(1);
      end
      if (issue_s) begin
        outstanding_r <= 1'b1;
      end else if ((src_valid && outstanding_r) || timeout_s) begin
        outstanding_r <= 1'b0;
      end
    end
  end

`ifdef ECG_SAMPLE_SCHED_TIMEOUT_EN
  logic [TO_CNT_WIDTH-1:0] to_cnt_r;
  logic                    src_timeout_r;

  assign timeout_s   = outstanding_r && !src_valid && (to_cnt_r == TO_CNT_WIDTH'(TIMEOUT_LIMIT - 1));
  assign src_timeout = src_timeout_r;

  // Age of the outstanding request and the sticky timeout flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt_r      <= TO_CNT_WIDTH'(0);
      src_timeout_r <= 1'b0;
    end else begin
      if (issue_s) begin
        to_cnt_r <= TO_CNT_WIDTH'(0);
      end else if (outstanding_r && !src_valid) begin
        to_cnt_r <= to_cnt_r + TO_CNT_WIDTH'(1);
      end
      if (start_acc_s) begin
        src_timeout_r <= 1'b0;
      end else if (timeout_s) begin
        src_timeout_r <= 1'b1;
      end
    end
  end
`else
  assign timeout_s   = 1'b0;
  assign src_timeout = 1'b0;
`endif

  ecg_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push_s),
    .push_data (src_data),
    .pop       (pop_s),
    .pop_data  (out_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_ecg_sample_sched.sv
// Scoreboard bench for ecg_sample_sched: source model pushes expected samples, monitor checks the stream.
// Directed scenarios plus randomized runs; timeout scenario only when ECG_SAMPLE_SCHED_TIMEOUT_EN is defined.
module tb_ecg_sample_sched;

  typedef struct {
    logic [10:0] data;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] rate_div = 16'd0;
  logic [23:0] num_samples = 24'd0;
  logic        src_req;
  logic [10:0] src_data = 11'd0;
  logic        src_valid = 1'b0;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_index;
  logic        busy, done, overrun, src_timeout;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   exp_idx = 0;
  int   rdy_mode = 1;
  int   src_en = 1;
  int   src_lat_max = 1;
  int   stray_en = 0;
  int   req_run = 0, pop_run = 0, done_run = 0;
  int   gap_min = 1000000, gap_max = 0;
  int   last_req = -1;
  int   cyc = 0;
  logic prev_req = 1'b0;

  ecg_sample_sched dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .stop        (stop),
    .rate_div    (rate_div),
    .num_samples (num_samples),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .src_timeout (src_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sample source: answers each request after 1..src_lat_max cycles, records the expected output.
  initial forever begin
    @(negedge clk);
    if (nrst && src_req && src_en != 0) begin
      int   lat;
      exp_t e;
      lat = $urandom_range(1, src_lat_max);
      repeat (lat) @(posedge clk);
      #1;
      src_data  = 11'($urandom);
      src_valid = 1'b1;
      e.data = src_data;
      e.idx  = exp_idx;
      exp_q.push_back(e);
      exp_idx++;
      @(posedge clk); #1;
      src_valid = 1'b0;
      if (stray_en != 0) begin
        src_data  = 11'($urandom);
        src_valid = 1'b1;
        @(posedge clk); #1;
        src_valid = 1'b0;
      end
    end
  end

  // Output consumer backpressure.
  initial forever begin
    @(posedge clk); #1;
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Monitor: per-run statistics and scoreboard comparison of every accepted output.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!nrst) begin
      prev_req = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        req_run = 0; pop_run = 0; done_run = 0;
        last_req = -1; gap_min = 1000000; gap_max = 0;
      end
      if (src_req) begin
        chk("req_single_cycle", 32'(prev_req), 32'd0);
        if (last_req >= 0) begin
          if (cyc - last_req < gap_min) gap_min = cyc - last_req;
          if (cyc - last_req > gap_max) gap_max = cyc - last_req;
        end
        last_req = cyc;
        req_run++;
      end
      prev_req = src_req;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_index", 32'(out_index), 32'(e.idx));
        end
        pop_run++;
      end
      if (done) begin
        done_run++;
        chk("busy_low_at_done", 32'(busy), 32'd0);
`ifndef ECG_SAMPLE_SCHED_TIMEOUT_EN
        chk("src_timeout_const", 32'(src_timeout), 32'd0);
`endif
      end
    end
  end

  task automatic start_run(input int div, input int num);
    @(posedge clk); #1;
    rate_div    = 16'(div);
    num_samples = 24'(num);
    exp_idx     = 0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_run == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'(done_run != 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_reqs(input int k, input int budget);
    int n;
    n = 0;
    while (req_run < k && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_within_budget", 32'(req_run >= k), 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_src_req", 32'(src_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_src_timeout", 32'(src_timeout), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    nrst = 1'b1;

    // basic paced run: requests every 4 cycles, 5 samples
    rdy_mode = 1;
    start_run(4, 5);
    wait_done(300);
    chk("basic_reqs", 32'(req_run), 32'd5);
    chk("basic_pops", 32'(pop_run), 32'd5);
    chk("basic_done_pulse", 32'(done_run), 32'd1);
    chk("basic_gap_min", 32'(gap_min), 32'd4);
    chk("basic_gap_max", 32'(gap_max), 32'd4);
    chk("basic_overrun", 32'(overrun), 32'd0);

    // backpressure: FIFO fills, further ticks overrun, busy held
    rdy_mode = 0;
    start_run(2, 10);
    repeat (60) @(negedge clk);
    chk("bp_reqs_capped", 32'(req_run), 32'd4);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_busy_held", 32'(busy), 32'd1);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    rdy_mode = 1;
    wait_done(400);
    chk("bp_reqs_total", 32'(req_run), 32'd10);
    chk("bp_pops_total", 32'(pop_run), 32'd10);
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);

    // stop after third request
    start_run(4, 10);
    wait_reqs(3, 100);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(200);
    chk("stop_reqs", 32'(req_run), 32'd3);
    chk("stop_pops", 32'(pop_run), 32'd3);
    chk("stop_done_pulse", 32'(done_run), 32'd1);
    chk("stop_idle", 32'(busy || done), 32'd0);

    // asynchronous reset with two samples buffered
    rdy_mode = 0;
    start_run(4, 10);
    begin
      int n;
      n = 0;
      while (exp_q.size() < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("pre_reset_buffered", 32'(out_valid), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_src_req", 32'(src_req), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    rdy_mode = 1;
    start_run(4, 3);
    wait_done(200);
    chk("post_reset_pops", 32'(pop_run), 32'd3);

    // zero-length run: done in the second cycle, no requests
    start_run(5, 0);
    chk("zero_done_cycle2", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("zero_done_one_cycle", 32'(done), 32'd0);
    chk("zero_reqs", 32'(req_run), 32'd0);

    // start during RUN is ignored (rate and length unchanged)
    start_run(8, 3);
    wait_reqs(1, 50);
    @(posedge clk); #1;
    rate_div = 16'd2;
    num_samples = 24'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    chk("ignored_start_reqs", 32'(req_run), 32'd3);
    chk("ignored_start_gap", 32'(gap_max), 32'd8);
    chk("ignored_start_done", 32'(done_run), 32'd1);

    // randomized runs: random rate, length, latency, backpressure, stray source pulses
    rdy_mode = 2;
    src_lat_max = 3;
    stray_en = 1;
    for (int r = 0; r < 8; r++) begin
      int dv, nm;
      dv = $urandom_range(0, 7);
      nm = $urandom_range(1, 8);
      start_run(dv, nm);
      wait_done(3000);
      chk("rand_reqs", 32'(req_run), 32'(nm));
      chk("rand_pops", 32'(pop_run), 32'(nm));
      chk("rand_done_pulse", 32'(done_run), 32'd1);
      if (dv >= 6) chk("rand_gap_min", 32'(gap_min >= dv), 32'd1);
    end
    stray_en = 0;
    src_lat_max = 1;
    rdy_mode = 1;

`ifdef ECG_SAMPLE_SCHED_TIMEOUT_EN
    // silent source: each request times out 16 cycles later, pacing continues
    src_en = 0;
    start_run(40, 2);
    wait_reqs(1, 100);
    begin
      int n;
      n = 0;
      while (!src_timeout && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", 32'(n), 32'd16);
    end
    wait_done(200);
    chk("timeout_reqs_resume", 32'(req_run), 32'd2);
    chk("timeout_sticky", 32'(src_timeout), 32'd1);
    src_en = 1;
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ecg_sample_sched.md
ECG_SAMPLE_SCHED -- requirements
Module: ecg_sample_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, sample width.
REQ-002 SHALL have parameter CTR_WIDTH, default 24, sample counter/index width.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, rate divider width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: run request pulse.
REQ-008 SHALL have port stop, input, 1: abort request pulse.
REQ-009 SHALL have port rate_div, input, DIV_WIDTH: clk cycles per sample tick.
REQ-010 SHALL have port num_samples, input, CTR_WIDTH: samples to fetch per run.
REQ-011 SHALL have port src_req, output, 1: one-cycle fetch request to sample source.
REQ-012 SHALL have port src_data, input, DATA_WIDTH: source sample.
REQ-013 SHALL have port src_valid, input, 1: src_data valid, one cycle per request.
REQ-014 SHALL have ports out_data (output, DATA_WIDTH), out_valid (output, 1), out_ready (input, 1): sample stream to algorithm core.
REQ-015 SHALL have port out_index, output, CTR_WIDTH: index of sample on out_data.
REQ-016 SHALL have ports busy, done, overrun, src_timeout (outputs, 1 each): status.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN, DONE; start in IDLE latches rate_div (values <2 forced to 2) and num_samples, clears issued count, out_index, overrun, src_timeout; moves to RUN, or to DONE if num_samples==0.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 In RUN, SHALL count down from latched rate_div-1; tick on reaching 0, reload same cycle.
REQ-020 On tick, SHALL assert src_req for exactly one cycle if no request outstanding and FIFO occupancy plus outstanding < FIFO_DEPTH, and increment issued count.
REQ-021 On tick blocked by outstanding request or full FIFO, SHALL issue nothing, not increment issued count, set overrun (sticky until next start).
REQ-022 SHALL push src_data into FIFO on each src_valid and clear outstanding; src_valid with no outstanding request SHALL be discarded.
REQ-023 SHALL go RUN->DRAIN when issued count equals num_samples, or on stop (stop wins over a same-cycle tick: no src_req).
REQ-024 In DRAIN, SHALL issue no requests; go to DONE when no request outstanding and FIFO empty.
REQ-025 DONE SHALL last one cycle with done=1, then IDLE; busy=1 in RUN and DRAIN only.
REQ-026 out_valid SHALL equal FIFO non-empty; out_data SHALL be FIFO head; pop on out_valid&&out_ready; out_index increments per pop, 0 for first sample of a run.
REQ-027 Simultaneous push and pop on full FIFO SHALL be impossible by REQ-020; on empty FIFO push and pop same cycle SHALL not bypass (data appears next cycle).

Reset
REQ-028 On nrst low, SHALL go to IDLE immediately, flush FIFO, clear outstanding; src_req, out_valid, busy, done, overrun, src_timeout =0; out_index, counters =0; mid-run reset discards all data.

Configuration
REQ-029 With ECG_SAMPLE_SCHED_TIMEOUT_EN defined, SHALL clear outstanding and set sticky src_timeout if src_valid not seen within 16 cycles of src_req; issued count not decremented.
REQ-030 Without ECG_SAMPLE_SCHED_TIMEOUT_EN, src_timeout SHALL be constant 0 and outstanding waits indefinitely.

Structure
REQ-031 Package ecg_sched_pkg SHALL hold FSM state enum, default parameter constants, timeout limit 16.
REQ-032 FIFO SHALL be sub-module ecg_sync_fifo (DATA_WIDTH, FIFO_DEPTH, push/pop/full/empty/count).

Verification
REQ-033 rate_div=4, num_samples=5, out_ready=1, source 1-cycle latency -> src_req every 4 cycles, 5 samples out, out_index 0..4, done one pulse, overrun=0.
REQ-034 rate_div=2, out_ready=0, FIFO_DEPTH=4, num_samples=10 -> exactly 4 requests, overrun=1, busy held until out_ready released.
REQ-035 stop asserted after 3rd src_req, out_ready=1 -> no further src_req, 3 samples delivered, done pulse, IDLE.
REQ-036 nrst low mid-RUN with 2 samples buffered -> out_valid=0 same cycle, IDLE, next start gives out_index 0.
REQ-037 num_samples=0 start -> no src_req, done pulse second cycle; start during RUN ignored.
REQ-038 TIMEOUT_EN defined, source never answers -> src_timeout=1 after 16 cycles, requests resume next tick.
